data_mem_access_unit: RTL and testbench
=======================================

# data_mem_access_unit

MEM-stage load/store engine of the pipelined RV32I core. Consumes the memory controls produced at decode (MemRead, MemWrite, funct3 width) with the EX-stage address and store data. Drives a ready-handshaked data-memory port, stalls the pipeline for the duration of each access, and returns width-adjusted load data for the MEM/WB register.

## Interface
- TIMEOUT, 16: max BUSY cycles waiting on dmem_ready before abort.
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- MEM_cntl_MemRead  in  1  load in MEM stage
- MEM_cntl_MemWrite  in  1  store in MEM stage
- MEM_funct  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
- MEM_ALUResult  in  32  byte address
- MEM_WriteData  in  32  store data (rs2)
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_ready  in  1  access complete (read data valid this cycle)
- dmem_rdata  in  32  read word
- MEM_stall  out  1  freeze IF..MEM, bubble into WB
- MEM_DMemReadData_width  out  32  extended load result
- MEM_access_fault  out  1  one-cycle pulse: misaligned, illegal funct, or timeout

## Operation
- FSM states IDLE, BUSY, DONE; reset to IDLE.
- IDLE: no access (Read=Write=0) -> stall 0, stay. Legal access -> stall 1, latch addr/we/be/wdata/funct, -> BUSY. Illegal access -> no request, stall 0, fault 1, read data 0, stay IDLE.
- Illegal: h/hu/sh with addr[0]=1; w with addr[1:0]!=0; load funct in {011,110,111}; store funct >010; Read and Write both 1.
- BUSY: dmem_req 1, all dmem_* outputs held stable from latches; stall 1; timeout counter increments. dmem_ready=1 -> capture dmem_rdata (loads) into data register, -> DONE. Counter reaching TIMEOUT-1 without ready -> data register 0, fault flag set, -> DONE.
- DONE: dmem_req 0, stall 0, MEM_DMemReadData_width driven from extracted register, fault pulses if timeout flagged; -> IDLE unconditionally (pipeline advances at this edge).
- Store lanes: sb be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}; sh be=4'b0011<<{addr[1],1'b0}, wdata={2{rs2[15:0]}}; sw be=4'b1111.
- Load extract: byte/half selected by addr[1:0]; b/h sign-extend, bu/hu zero-extend, w passthrough. Stores return 0.

## Timing
- Reset values: dmem_req 0, dmem_we 0, dmem_addr 0, dmem_be 0, dmem_wdata 0, MEM_stall 0, MEM_DMemReadData_width 0, MEM_access_fault 0, counter 0.
- MEM_stall combinational from state and IDLE inputs; dmem_* registered.
- Best case (ready in first BUSY cycle): instruction occupies MEM 3 cycles (IDLE, BUSY, DONE); each extra wait cycle adds one.
- dmem_req never drops in BUSY before ready or timeout; a ready seen in the timeout cycle wins over timeout.
- Ready asserted in IDLE/DONE is ignored.
- Async reset mid-BUSY: req drops immediately, access abandoned, no fault pulse.
- Counter is 32-bit-safe width $clog2(TIMEOUT)+1, cleared on entry to BUSY.

## Structure
- Shared package (core_pkg): funct3 width constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum, TIMEOUT default.
- Sub-module mem_lane_align: combinational store packing (be, wdata) and load extraction/extension; instanced twice-usable, once for store path, once for load path.

## Test plan
- lw addr 0x100, ready after 2 wait cycles, rdata 0xDEADBEEF -> req held 3 BUSY cycles, stall 4 cycles, result 0xDEADBEEF, no fault.
- lb addr 0x103, rdata 0x80FF_0000 -> result 0xFFFFFF80; lbu same -> 0x00000080.
- sh addr 0x202, rs2 0x1234ABCD -> dmem_addr 0x200, be 4'b1100, wdata 0xABCDABCD, we 1.
- lw addr 0x101 -> no dmem_req, fault pulse 1 cycle, stall 0.
- sw, ready never asserted, TIMEOUT=16 -> req 16 cycles, DONE with fault pulse, result 0, back to IDLE.
- rst asserted in BUSY -> req 0 same cycle, all outputs reset values, next lw proceeds normally.

Source files
------------

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the RV32I data-memory access path:
//   - funct3 load/store width codes
//   - MEM-stage access FSM state encoding
//   - default ready timeout
//   - access legality helper (alignment, funct3 and Read/Write conflicts)
// -----------------------------------------------------------------------------
package core_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mem_state_e;

  // Returns 1 when the requested access must be refused without touching memory.
  // An idle slot (no read, no write) is never illegal.
  function automatic logic access_illegal(input logic       rd,
                                          input logic       wr,
                                          input logic [2:0] funct,
                                          input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (rd && wr) begin
      bad = 1'b1;
    end else if (rd) begin
      case (funct)
        F3_B, F3_BU: bad = 1'b0;
        F3_H, F3_HU: bad = addr_lo[0];
        F3_W:        bad = |addr_lo;
        default:     bad = 1'b1;
      endcase
    end else if (wr) begin
      case (funct)
        F3_B:    bad = 1'b0;
        F3_H:    bad = addr_lo[0];
        F3_W:    bad = |addr_lo;
        default: bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
// Purely combinational byte-lane helper. The store half packs rs2 into the
// addressed lanes; the load half extracts and extends a byte/half/word from a
// read word. Either half may be left unused by the instantiating module.
//
// Ports:
//   funct_i       in  3   funct3 width code
//   addr_lo_i     in  2   byte offset within the word
//   store_data_i  in  32  raw store data (rs2)
//   load_word_i   in  32  raw read word from memory
//   be_o          out 4   byte enables for the addressed lanes
//   wdata_o       out 32  lane-replicated store data
//   load_data_o   out 32  extracted, sign/zero-extended load result
// -----------------------------------------------------------------------------
module mem_lane_align
  import core_pkg::*;
(
  input  logic [2:0]  funct_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o
);

  // Store packing keys on funct3[1:0] only, so unsigned load codes map onto
  // the same lane masks as their signed counterparts.
  always_comb begin
    // NOTE: defaults first on every combinational output so no branch can infer a latch.
    be_o    = 4'b1111;
    wdata_o = store_data_i;
    case (funct_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      2'b01: begin
        be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o = {2{store_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Shift the addressed byte/half down to bit 0; only the low 16 bits are needed.
  logic [15:0] shifted;
  assign shifted = 16'(load_word_i >> {addr_lo_i, 3'b000});

  always_comb begin
    load_data_o = '0;
    case (funct_i)
      F3_B:    load_data_o = {{24{shifted[7]}},  shifted[7:0]};
      F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    load_data_o = load_word_i;
      F3_BU:   load_data_o = {24'b0, shifted[7:0]};
      F3_HU:   load_data_o = {16'b0, shifted[15:0]};
      default: load_data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_access_unit.sv
// -----------------------------------------------------------------------------
// data_mem_access_unit
// MEM-stage load/store engine. Accepts a load or store from the EX/MEM
// register, issues it on a ready-handshaked data-memory port, stalls the
// pipeline while the access is outstanding and returns the width-adjusted load
// result. Misaligned/illegal accesses and ready timeouts raise a one-cycle fault.
//
// Ports:
//   clk                     in  1   core clock
//   rst                     in  1   asynchronous active-high reset
//   MEM_cntl_MemRead        in  1   load in MEM stage
//   MEM_cntl_MemWrite       in  1   store in MEM stage
//   MEM_funct               in  3   funct3 width code
//   MEM_ALUResult           in  32  byte address
//   MEM_WriteData           in  32  store data (rs2)
//   dmem_req                out 1   request valid
//   dmem_we                 out 1   1 = write
//   dmem_addr               out 32  word-aligned address
//   dmem_be                 out 4   byte enables
//   dmem_wdata              out 32  lane-replicated store data
//   dmem_ready              in  1   access complete / read data valid
//   dmem_rdata              in  32  read word
//   MEM_stall               out 1   freeze IF..MEM
//   MEM_DMemReadData_width  out 32  extended load result (valid in DONE)
//   MEM_access_fault        out 1   one-cycle fault pulse
// -----------------------------------------------------------------------------
module data_mem_access_unit
  import core_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_cntl_MemRead,
  input  logic        MEM_cntl_MemWrite,
  input  logic [2:0]  MEM_funct,
  input  logic [31:0] MEM_ALUResult,
  input  logic [31:0] MEM_WriteData,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        MEM_stall,
  output logic [31:0] MEM_DMemReadData_width,
  output logic        MEM_access_fault
);

  localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic [2:0]       funct_q;
  logic [1:0]       addr_lo_q;
  logic [31:0]      data_q;
  logic             tmo_q;

  logic        access;
  logic        illegal;
  logic        legal;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic [31:0] unused_st_load;
  logic [3:0]  unused_ld_be;
  logic [31:0] unused_ld_wdata;

  assign access  = MEM_cntl_MemRead | MEM_cntl_MemWrite;
  assign illegal = access_illegal(MEM_cntl_MemRead, MEM_cntl_MemWrite,
                                  MEM_funct, MEM_ALUResult[1:0]);
  assign legal   = access & ~illegal;

  // Store path: packs the incoming instruction's lanes before they are latched.
  mem_lane_align u_store_align (
    .funct_i      (MEM_funct),
    .addr_lo_i    (MEM_ALUResult[1:0]),
    .store_data_i (MEM_WriteData),
    .load_word_i  (32'b0),
    .be_o         (st_be),
    .wdata_o      (st_wdata),
    .load_data_o  (unused_st_load)
  );

  // Load path: extracts from the returned word using the latched offset/width.
  mem_lane_align u_load_align (
    .funct_i      (funct_q),
    .addr_lo_i    (addr_lo_q),
    .store_data_i (32'b0),
    .load_word_i  (dmem_rdata),
    .be_o         (unused_ld_be),
    .wdata_o      (unused_ld_wdata),
    .load_data_o  (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      funct_q   <= '0;
      addr_lo_q <= '0;
      data_q    <= '0;
      tmo_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register sees pre-edge values regardless of order.
      unique case (state_q)
        S_IDLE: begin
          if (legal) begin
            state_q   <= S_BUSY;
            req_q     <= 1'b1;
            we_q      <= MEM_cntl_MemWrite;
            addr_q    <= {MEM_ALUResult[31:2], 2'b00};
            be_q      <= st_be;
            wdata_q   <= MEM_cntl_MemWrite ? st_wdata : 32'b0;
            funct_q   <= MEM_funct;
            addr_lo_q <= MEM_ALUResult[1:0];
            cnt_q     <= '0;
            tmo_q     <= 1'b0;
          end
        end
        S_BUSY: begin
          // Ready is checked first so a ready in the final timeout cycle still completes.
          if (dmem_ready) begin
            data_q  <= we_q ? 32'b0 : ld_data;
            req_q   <= 1'b0;
            state_q <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            data_q  <= '0;
            tmo_q   <= 1'b1;
            req_q   <= 1'b0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          tmo_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

  // Stall must rise in the same cycle the access is presented, so it is decoded
  // from state and the live controls; held low while reset is asserted.
  assign MEM_stall = ~rst & (((state_q == S_IDLE) & legal) | (state_q == S_BUSY));

  // The result is only meaningful in DONE; everywhere else the WB side sees 0.
  assign MEM_DMemReadData_width = (state_q == S_DONE) ? data_q : 32'b0;

  assign MEM_access_fault = ~rst & (((state_q == S_IDLE) & illegal) |
                                    ((state_q == S_DONE) & tmo_q));

endmodule

// File: tb/tb_data_mem_access_unit.sv
`timescale 1ns/1ps
module tb_data_mem_access_unit;
  import core_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_funct;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic [31:0] mem_rdata_w;
  logic        mem_fault;

  always #5 clk = ~clk;

  data_mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .MEM_cntl_MemRead       (mem_read),
    .MEM_cntl_MemWrite      (mem_write),
    .MEM_funct              (mem_funct),
    .MEM_ALUResult          (mem_addr),
    .MEM_WriteData          (mem_wd),
    .dmem_req               (dmem_req),
    .dmem_we                (dmem_we),
    .dmem_addr              (dmem_addr),
    .dmem_be                (dmem_be),
    .dmem_wdata             (dmem_wdata),
    .dmem_ready             (dmem_ready),
    .dmem_rdata             (dmem_rdata),
    .MEM_stall              (mem_stall),
    .MEM_DMemReadData_width (mem_rdata_w),
    .MEM_access_fault       (mem_fault)
  );

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        fault;
    int          busy;
    int          stall;
  } rsp_t;

  req_t req_sb[$];
  rsp_t rsp_sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  logic prev_req  = 1'b0;
  logic cur_valid = 1'b0;
  int   busy_cnt  = 0;
  int   stall_cnt = 0;
  req_t cur;
  rsp_t rsp;

  always @(negedge clk) begin
    if (rst) begin
      prev_req  = 1'b0;
      cur_valid = 1'b0;
      busy_cnt  = 0;
      stall_cnt = 0;
    end else begin
      if (dmem_req)  busy_cnt++;
      if (mem_stall) stall_cnt++;

      if (dmem_req && !prev_req) begin
        if (req_sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_req: got request addr 0x%08h expected none", dmem_addr);
        end else begin
          cur = req_sb.pop_front();
          cur_valid = 1'b1;
          check({cur.tag, "_addr"},  64'(dmem_addr),  64'(cur.addr));
          check({cur.tag, "_we"},    64'(dmem_we),    64'(cur.we));
          check({cur.tag, "_be"},    64'(dmem_be),    64'(cur.be));
          check({cur.tag, "_wdata"}, 64'(dmem_wdata), 64'(cur.wdata));
        end
      end else if (dmem_req && cur_valid) begin
        check({cur.tag, "_hold_addr_wdata"}, {dmem_addr, dmem_wdata}, {cur.addr, cur.wdata});
        check({cur.tag, "_hold_we_be"}, 64'({dmem_we, dmem_be}), 64'({cur.we, cur.be}));
      end

      if (!dmem_req && prev_req) begin
        cur_valid = 1'b0;
        if (rsp_sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: got completion data 0x%08h expected none", mem_rdata_w);
        end else begin
          rsp = rsp_sb.pop_front();
          check({rsp.tag, "_result"},    64'(mem_rdata_w), 64'(rsp.data));
          check({rsp.tag, "_fault"},     64'(mem_fault),   64'(rsp.fault));
          check({rsp.tag, "_done_stall"}, 64'(mem_stall),  64'(0));
          check({rsp.tag, "_req_cycles"}, 64'(busy_cnt),   64'(rsp.busy));
          check({rsp.tag, "_stall_cycles"}, 64'(stall_cnt), 64'(rsp.stall));
        end
        busy_cnt  = 0;
        stall_cnt = 0;
      end else if (!dmem_req && !prev_req && mem_fault) begin
        if (rsp_sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_fault: got fault pulse expected none");
        end else begin
          rsp = rsp_sb.pop_front();
          check({rsp.tag, "_fault"},        64'(mem_fault),   64'(rsp.fault));
          check({rsp.tag, "_result"},       64'(mem_rdata_w), 64'(rsp.data));
          check({rsp.tag, "_stall_cycles"}, 64'(stall_cnt),   64'(rsp.stall));
        end
        busy_cnt  = 0;
        stall_cnt = 0;
      end

      prev_req = dmem_req;
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic clear_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_funct = 3'b000;
    mem_addr  = 32'h0;
    mem_wd    = 32'h0;
  endtask

  // waits = BUSY cycles without ready before ready is given; negative = never.
  task automatic run_op(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] word, input int waits, input logic legal,
                        input logic [3:0] e_be, input logic [31:0] e_wdata,
                        input logic [31:0] e_data, input logic e_fault);
    int busy;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; mem_funct = f; mem_addr = a; mem_wd = wd;
    dmem_ready = 1'b0;
    if (!legal) begin
      rsp_sb.push_back('{tag: tag, data: 32'h0, fault: 1'b1, busy: 0, stall: 0});
      @(posedge clk); #1;
      clear_inputs();
      return;
    end
    busy = (waits < 0) ? TIMEOUT : waits + 1;
    req_sb.push_back('{tag: tag, addr: {a[31:2], 2'b00}, we: wr, be: e_be, wdata: e_wdata});
    rsp_sb.push_back('{tag: tag, data: e_data, fault: e_fault, busy: busy, stall: busy + 1});
    @(posedge clk); #1;
    for (int k = 0; k < busy; k++) begin
      dmem_ready = (k == waits);
      dmem_rdata = (k == waits) ? word : 32'hA5A5_5A5A;
      @(posedge clk); #1;
    end
    dmem_ready = 1'b0;
    clear_inputs();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    dmem_ready = 1'b0;
    dmem_rdata = 32'h0;
    #22;
    check("rst_req",    64'(dmem_req),    64'(0));
    check("rst_we",     64'(dmem_we),     64'(0));
    check("rst_addr",   64'(dmem_addr),   64'(0));
    check("rst_be",     64'(dmem_be),     64'(0));
    check("rst_wdata",  64'(dmem_wdata),  64'(0));
    check("rst_stall",  64'(mem_stall),   64'(0));
    check("rst_result", 64'(mem_rdata_w), 64'(0));
    check("rst_fault",  64'(mem_fault),   64'(0));
    rst = 1'b0;

    //     tag            rd wr funct  addr          wd            word          wt  ok be       wdata         result        flt
    run_op("lw_wait2",    1, 0, F3_W,  32'h100, 32'h0,        32'hDEADBEEF, 2,  1, 4'b1111, 32'h0,        32'hDEADBEEF, 0);
    run_op("lb_103",      1, 0, F3_B,  32'h103, 32'h0,        32'h80FF0000, 0,  1, 4'b1000, 32'h0,        32'hFFFFFF80, 0);
    run_op("lbu_103",     1, 0, F3_BU, 32'h103, 32'h0,        32'h80FF0000, 0,  1, 4'b1000, 32'h0,        32'h00000080, 0);
    run_op("sh_202",      0, 1, F3_H,  32'h202, 32'h1234ABCD, 32'h0,        1,  1, 4'b1100, 32'hABCDABCD, 32'h0,        0);
    run_op("lw_101_ill",  1, 0, F3_W,  32'h101, 32'h0,        32'h0,        0,  0, 4'b0000, 32'h0,        32'h0,        1);
    run_op("sw_timeout",  0, 1, F3_W,  32'h300, 32'hCAFEF00D, 32'h0,        -1, 1, 4'b1111, 32'hCAFEF00D, 32'h0,        1);
    run_op("lw_rdy_last", 1, 0, F3_W,  32'h104, 32'h0,        32'h11223344, 15, 1, 4'b1111, 32'h0,        32'h11223344, 0);
    run_op("lh_102",      1, 0, F3_H,  32'h102, 32'h0,        32'h80017FFF, 0,  1, 4'b1100, 32'h0,        32'hFFFF8001, 0);
    run_op("lhu_100",     1, 0, F3_HU, 32'h100, 32'h0,        32'h8001F00F, 3,  1, 4'b0011, 32'h0,        32'h0000F00F, 0);
    run_op("sb_105",      0, 1, F3_B,  32'h105, 32'h000000A5, 32'h0,        0,  1, 4'b0010, 32'hA5A5A5A5, 32'h0,        0);
    run_op("lb_100",      1, 0, F3_B,  32'h100, 32'h0,        32'h123456F7, 1,  1, 4'b0001, 32'h0,        32'hFFFFFFF7, 0);
    run_op("lb_101",      1, 0, F3_B,  32'h101, 32'h0,        32'h123456F7, 0,  1, 4'b0010, 32'h0,        32'h00000056, 0);
    run_op("sw_104",      0, 1, F3_W,  32'h104, 32'h01020304, 32'h0,        0,  1, 4'b1111, 32'h01020304, 32'h0,        0);
    run_op("sh_201_ill",  0, 1, F3_H,  32'h201, 32'h0,        32'h0,        0,  0, 4'b0000, 32'h0,        32'h0,        1);
    run_op("ld_f011_ill", 1, 0, 3'b011,32'h100, 32'h0,        32'h0,        0,  0, 4'b0000, 32'h0,        32'h0,        1);
    run_op("rdwr_ill",    1, 1, F3_W,  32'h100, 32'h0,        32'h0,        0,  0, 4'b0000, 32'h0,        32'h0,        1);
    run_op("st_f100_ill", 0, 1, 3'b100,32'h100, 32'h0,        32'h0,        0,  0, 4'b0000, 32'h0,        32'h0,        1);
    run_op("lhu_103_ill", 1, 0, F3_HU, 32'h103, 32'h0,        32'h0,        0,  0, 4'b0000, 32'h0,        32'h0,        1);

    // Ready while idle must not start or complete anything.
    @(posedge clk); #1;
    dmem_ready = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1 dmem_ready = 1'b0;
    run_op("lw_after_idle_rdy", 1, 0, F3_W, 32'h010, 32'h0, 32'h0BADF00D, 1, 1, 4'b1111, 32'h0, 32'h0BADF00D, 0);

    // Reset in the middle of a BUSY access.
    @(posedge clk); #1;
    mem_read = 1'b1; mem_funct = F3_W; mem_addr = 32'h400;
    req_sb.push_back('{tag: "lw_rst", addr: 32'h400, we: 1'b0, be: 4'b1111, wdata: 32'h0});
    @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_busy_req",    64'(dmem_req),    64'(0));
    check("rst_busy_addr",   64'(dmem_addr),   64'(0));
    check("rst_busy_be",     64'(dmem_be),     64'(0));
    check("rst_busy_stall",  64'(mem_stall),   64'(0));
    check("rst_busy_fault",  64'(mem_fault),   64'(0));
    check("rst_busy_result", 64'(mem_rdata_w), 64'(0));
    clear_inputs();
    @(negedge clk); #2;
    rst = 1'b0;
    run_op("lw_post_rst", 1, 0, F3_W, 32'h008, 32'h0, 32'h55AA55AA, 0, 1, 4'b1111, 32'h0, 32'h55AA55AA, 0);

    repeat (3) @(posedge clk);
    #1;
    check("req_sb_drained", 64'(req_sb.size()), 64'(0));
    check("rsp_sb_drained", 64'(rsp_sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
